// File: rtl/ex_mem_pipe_stage_if.sv
// rtl/ex_mem_pipe_stage_if.sv - EX->MEM stage handshake/payload bundle
// master drives the EX side and out_ready; slave is the pipeline stage itself.
interface ex_mem_pipe_stage_if #(
  parameter int DATA_W = 149,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// rtl/ex_mem_pipe_stage.sv - EX->MEM valid/ready stage with flush, bubble masking and stall counter
// Define EX_MEM_SKID_EN for the skid build with a registered in_ready; default is the 2-state build.
module ex_mem_pipe_stage #(
  parameter int DATA_W = 149,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic               CLK,
  input  logic               RESETn,
  ex_mem_pipe_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [DATA_W-1:0] w_main_data_d;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_load_main;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

`ifdef EX_MEM_SKID_EN
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_in_ready;
  logic              w_load_skid;
  logic              w_skid_to_main;

  assign w_in_ready    = r_in_ready;
  assign w_main_data_d = w_skid_to_main ? r_skid_data : bus.in_data;
  assign w_main_ctrl_d = w_skid_to_main ? r_skid_ctrl : bus.in_ctrl;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = ST_TWO;
            w_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_state_nxt    = ST_ONE;
            w_load_main    = 1'b1;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready is the registered image of "next state is not full", so out_ready never reaches it
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_load_skid) begin
        r_skid_data <= bus.in_data;
      end
      if (bus.flush) begin
        r_skid_ctrl <= '0;
      end else if (w_load_skid) begin
        r_skid_ctrl <= bus.in_ctrl;
      end
    end
  end
`else
  assign w_in_ready    = bus.out_ready | ~w_out_valid;
  assign w_main_data_d = bus.in_data;
  assign w_main_ctrl_d = bus.in_ctrl;

  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire) begin
            w_load_main = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush only kills ctrl; payload bits are left as-is since they are masked by valid anyway
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
    end else begin
      if (w_load_main) begin
        r_main_data <= w_main_data_d;
      end
      if (bus.flush) begin
        r_main_ctrl <= '0;
      end else if (w_load_main) begin
        r_main_ctrl <= w_main_ctrl_d;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main_data;
  assign bus.out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};
  assign bus.stall_cnt = r_stall_cnt;

endmodule
